dm9000_if: RTL
==============

DM9000_IF -- requirements
Module: dm9000_if

Interface
REQ-001 SHALL have parameter T_SETUP, default 1, meaning wb_clk_i cycles with cs_n low and cmd valid before strobe, legal range 1..15.
REQ-002 SHALL have parameter T_STROBE, default 2, meaning cycles ior_n/iow_n are held low, legal range 1..15.
REQ-003 SHALL have parameter T_HOLD, default 1, meaning cycles cs_n, cmd and data are held after strobe release, legal range 0..15.
REQ-004 SHALL have parameter RST_CYCLES, default 16, meaning the length of the dm9000_rst_n low pulse after reset, legal range 1..255.
REQ-005 SHALL have port wb_clk_i, input, 1 bit: clock.
REQ-006 SHALL have port wb_rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have ports wb_dat_i (in, 32), wb_dat_o (out, 32), wb_adr_i (in, 32), wb_sel_i (in, 4), wb_we_i, wb_cyc_i, wb_stb_i (in, 1 each), and wb_ack_o, wb_err_o, wb_inta_o (out, 1 each): the Wishbone slave.
REQ-008 SHALL have ports dm9000_cs_n, dm9000_rst_n, dm9000_iow_n, dm9000_ior_n, dm9000_cmd (out, 1 each) and dm9000_oe (out, 1): the data-bus drive enable.
REQ-009 SHALL have ports dm9000_indata (in, 16), dm9000_outdata (out, 16) and dm9000_intr (in, 1, active-high).

Function
REQ-010 Address decode SHALL be: wb_adr_i[3]=0 selects a DM9000 cycle, with dm9000_cmd equal to wb_adr_i[2]; wb_adr_i[3]=1 selects the local CTRL register.
REQ-011 CTRL SHALL contain bit0 IEN (interrupt enable) and bit1 SRST; writing SRST=1 SHALL restart the reset pulse, and SRST SHALL self-clear.
REQ-012 A CTRL access SHALL be acked 1 cycle after acceptance; a read SHALL return {30'b0, 0, IEN}.
REQ-013 The FSM SHALL have the states PRST, IDLE, SETUP, STROBE, HOLD and ACK.
REQ-014 IDLE SHALL accept a request when wb_cyc_i&wb_stb_i, latching adr, we, sel and write data.
REQ-015 Transitions SHALL be: IDLE->SETUP->STROBE->HOLD->ACK->IDLE, with each timed state lasting its parameter count; HOLD SHALL be skipped when T_HOLD=0.
REQ-016 DM9000 cycle latency from acceptance to wb_ack_o SHALL be T_SETUP+T_STROBE+T_HOLD+1 cycles; wb_ack_o SHALL be a 1-cycle pulse.
REQ-017 dm9000_cs_n SHALL be low in SETUP, STROBE and HOLD, and high otherwise.
REQ-018 ior_n (read) or iow_n (write) SHALL be low in STROBE only.
REQ-019 dm9000_oe SHALL be high in SETUP, STROBE and HOLD of write cycles only.
REQ-020 Write lane steering SHALL be: if wb_sel_i[1:0]!=0, outdata=wb_dat_i[15:0], else outdata=wb_dat_i[31:16]; outdata SHALL be held stable from SETUP through HOLD.
REQ-021 Read data SHALL be captured from dm9000_indata on the last STROBE cycle, and wb_dat_o SHALL be {2{captured}}, valid while wb_ack_o is high.
REQ-022 wb_sel_i==0 at acceptance SHALL produce no bus cycle and a 1-cycle wb_err_o instead of ack; wb_err_o SHALL be 0 otherwise.
REQ-023 If wb_cyc_i drops mid-cycle, the bus cycle SHALL complete with full timing, and ACK SHALL still occur (it is ignored by the master).
REQ-024 In PRST, dm9000_rst_n SHALL be low for RST_CYCLES cycles, and requests SHALL be stalled (no ack or err) until the FSM reaches IDLE.

Reset
REQ-025 On wb_rst_i, the FSM SHALL enter PRST with its counter cleared, and IEN SHALL be 0.
REQ-026 On wb_rst_i, the outputs SHALL be: cs_n=1, ior_n=1, iow_n=1, cmd=0, oe=0, rst_n=0, outdata=0, wb_dat_o=0, ack=0, err=0, inta=0.
REQ-027 Reset asserted mid-cycle SHALL abort the cycle immediately with no ack.

Configuration
REQ-028 With macro DM9000_IRQ_SYNC_EN defined, dm9000_intr SHALL pass a 2-flop synchronizer, and wb_inta_o SHALL equal synced_intr&IEN, registered, giving 3 cycles of latency.
REQ-029 Without DM9000_IRQ_SYNC_EN, wb_inta_o SHALL equal registered dm9000_intr&IEN, giving 1 cycle of latency.

Verification
REQ-030 Reset release -> rst_n low for exactly 16 cycles; a request issued during this window SHALL be acked only after PRST plus the cycle latency.
REQ-031 Write with adr=0x4, sel=4'b1100, dat=0xABCD0000, defaults -> cmd=1, iow_n low for 2 cycles, outdata=0xABCD, ack 5 cycles after acceptance.
REQ-032 Read with adr=0x0, indata=0x1234 on the last STROBE cycle -> cmd=0, ior_n low for 2 cycles, wb_dat_o=0x12341234 with ack.
REQ-033 Access with sel=4'b0000 -> err pulse 1 cycle, cs_n stays 1, no ack.
REQ-034 Write CTRL=0x1, then intr=1 -> inta=1 after 3 cycles (SYNC_EN) or 1 cycle (without); CTRL=0x0 -> inta=0.
REQ-035 With T_HOLD=0 and T_SETUP=3, write -> cs_n low for 5 cycles and ack on the 6th cycle; write CTRL=0x2 -> rst_n pulse is restarted.

Source files
------------

// File: rtl/dm9000_if_if.sv
// Wishbone slave bus bundle for the DM9000 bridge.
// The master modport drives requests and the slave modport answers them.
interface dm9000_if_if;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_adr_i;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_ack_o;
   logic        wb_err_o;
   logic        wb_inta_o;

   modport slave (
      input  wb_dat_i, wb_adr_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
      output wb_dat_o, wb_ack_o, wb_err_o, wb_inta_o
   );

   modport master (
      output wb_dat_i, wb_adr_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
      input  wb_dat_o, wb_ack_o, wb_err_o, wb_inta_o
   );
endinterface

// File: rtl/dm9000_if.sv
// Wishbone-to-DM9000 bridge: timed cs/ior/iow cycles, a local CTRL register and the chip reset pulse.
// Define DM9000_IRQ_SYNC_EN to route dm9000_intr through a 2-flop synchronizer.
module dm9000_if #(
   parameter int T_SETUP    = 1,
   parameter int T_STROBE   = 2,
   parameter int T_HOLD     = 1,
   parameter int RST_CYCLES = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   dm9000_if_if.slave  wb,
   output logic        dm9000_cs_n,
   output logic        dm9000_rst_n,
   output logic        dm9000_iow_n,
   output logic        dm9000_ior_n,
   output logic        dm9000_cmd,
   output logic        dm9000_oe,
   input  logic [15:0] dm9000_indata,
   output logic [15:0] dm9000_outdata,
   input  logic        dm9000_intr
);

   typedef enum logic [2:0] {PRST, IDLE, SETUP, STROBE, HOLD, ACK} state_t;

   localparam logic [7:0] SETUP_LAST  = 8'(T_SETUP - 1);
   localparam logic [7:0] STROBE_LAST = 8'(T_STROBE - 1);
   localparam logic [7:0] HOLD_LAST   = 8'((T_HOLD > 0) ? T_HOLD - 1 : 0);
   localparam logic [7:0] RST_LAST    = 8'(RST_CYCLES - 1);

   state_t      r_state;
   logic [7:0]  r_cnt;
   logic        r_we;
   logic        r_ien;
   logic        r_srst;
   logic        r_csN;
   logic        r_rstN;
   logic        r_iowN;
   logic        r_iorN;
   logic        r_cmd;
   logic        r_oe;
   logic        r_ack;
   logic        r_err;
   logic        r_inta;
   logic [15:0] r_outData;
   logic [31:0] r_datO;

   logic        w_req;
   logic [15:0] w_lane;
   logic        w_unused;

   assign w_req    = wb.wb_cyc_i & wb.wb_stb_i;
   assign w_lane   = (wb.wb_sel_i[1:0] != 2'b00) ? wb.wb_dat_i[15:0] : wb.wb_dat_i[31:16];
   assign w_unused = ^{wb.wb_adr_i[31:4], wb.wb_adr_i[1:0]};

   // Every output is set on the transition into the state that owns it, so all pins come straight from flops.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state   <= PRST;
         r_cnt     <= '0;
         r_we      <= 1'b0;
         r_ien     <= 1'b0;
         r_srst    <= 1'b0;
         r_csN     <= 1'b1;
         r_rstN    <= 1'b0;
         r_iowN    <= 1'b1;
         r_iorN    <= 1'b1;
         r_cmd     <= 1'b0;
         r_oe      <= 1'b0;
         r_ack     <= 1'b0;
         r_err     <= 1'b0;
         r_outData <= '0;
         r_datO    <= '0;
      end else begin
         case (r_state)
            PRST: begin
               if (r_cnt == RST_LAST) begin
                  r_state <= IDLE;
                  r_rstN  <= 1'b1;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            IDLE: begin
               if (w_req) begin
                  r_we <= wb.wb_we_i;
                  if (wb.wb_sel_i == 4'b0000) begin
                     r_err   <= 1'b1;
                     r_state <= ACK;
                  end else if (wb.wb_adr_i[3]) begin
                     r_ack   <= 1'b1;
                     r_state <= ACK;
                     if (wb.wb_we_i) begin
                        r_ien  <= wb.wb_dat_i[0];
                        r_srst <= wb.wb_dat_i[1];
                     end else begin
                        r_datO <= {30'b0, 1'b0, r_ien};
                     end
                  end else begin
                     r_state <= SETUP;
                     r_cnt   <= '0;
                     r_csN   <= 1'b0;
                     r_cmd   <= wb.wb_adr_i[2];
                     r_oe    <= wb.wb_we_i;
                     if (wb.wb_we_i) begin
                        r_outData <= w_lane;
                     end
                  end
               end
            end
            SETUP: begin
               if (r_cnt == SETUP_LAST) begin
                  r_state <= STROBE;
                  r_cnt   <= '0;
                  r_iowN  <= ~r_we;
                  r_iorN  <= r_we;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            STROBE: begin
               if (r_cnt == STROBE_LAST) begin
                  r_cnt  <= '0;
                  r_iowN <= 1'b1;
                  r_iorN <= 1'b1;
                  if (!r_we) begin
                     r_datO <= {2{dm9000_indata}};
                  end
                  if (T_HOLD == 0) begin
                     r_state <= ACK;
                     r_csN   <= 1'b1;
                     r_oe    <= 1'b0;
                     r_ack   <= 1'b1;
                  end else begin
                     r_state <= HOLD;
                  end
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            HOLD: begin
               if (r_cnt == HOLD_LAST) begin
                  r_state <= ACK;
                  r_cnt   <= '0;
                  r_csN   <= 1'b1;
                  r_oe    <= 1'b0;
                  r_ack   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            ACK: begin
               r_ack <= 1'b0;
               r_err <= 1'b0;
               // A soft reset written to CTRL is acked first, then the chip reset pulse restarts.
               if (r_srst) begin
                  r_state <= PRST;
                  r_cnt   <= '0;
                  r_rstN  <= 1'b0;
                  r_srst  <= 1'b0;
               end else begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= PRST;
               r_cnt   <= '0;
               r_rstN  <= 1'b0;
            end
         endcase
      end
   end

`ifdef DM9000_IRQ_SYNC_EN
   logic r_intrMeta;
   logic r_intrSync;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_intrMeta <= 1'b0;
         r_intrSync <= 1'b0;
         r_inta     <= 1'b0;
      end else begin
         r_intrMeta <= dm9000_intr;
         r_intrSync <= r_intrMeta;
         r_inta     <= r_intrSync & r_ien;
      end
   end
`else
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_inta <= 1'b0;
      end else begin
         r_inta <= dm9000_intr & r_ien;
      end
   end
`endif

   assign dm9000_cs_n    = r_csN;
   assign dm9000_rst_n   = r_rstN;
   assign dm9000_iow_n   = r_iowN;
   assign dm9000_ior_n   = r_iorN;
   assign dm9000_cmd     = r_cmd;
   assign dm9000_oe      = r_oe;
   assign dm9000_outdata = r_outData;
   assign wb.wb_dat_o    = r_datO;
   assign wb.wb_ack_o    = r_ack;
   assign wb.wb_err_o    = r_err;
   assign wb.wb_inta_o   = r_inta;

endmodule
